// File: rtl/nox_uart_rx.sv
// nox_uart_rx: 8N1 UART receiver with 2-flop input synchronizer, show-ahead RX FIFO and sticky error flags.
module nox_uart_rx #(
    parameter int CLKS_PER_BIT = 607,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            uart_rx_i,
    input  logic                            rd_en_i,
    output logic [7:0]                      rd_data_o,
    output logic                            rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            rx_busy_o,
    output logic                            frame_err_o,
    output logic                            overrun_o,
    input  logic                            clr_err_i
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state;
    logic            rx_m, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      sh;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            tick, push, fe_set, pop, full, accept, ovr_set;

    assign tick    = cnt == BIT_LAST;
    assign push    = state == STOP && tick && rx_s;
    assign fe_set  = state == STOP && tick && !rx_s;
    assign pop     = rd_en_i && count != '0;
    assign full    = count == NW'(FIFO_DEPTH);
    assign accept  = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    assign rd_data_o    = mem[rd_ptr];
    assign rd_valid_o   = count != '0;
    assign fifo_count_o = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            rx_busy_o <= 1'b0;
        end else begin
            rx_m      <= uart_rx_i;
            rx_s      <= rx_m;
            rx_busy_o <= state != IDLE;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == HALF_LAST) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DATA: if (tick) begin
                    cnt         <= '0;
                    sh[bit_idx] <= rx_s;
                    bit_idx     <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // Leaving at mid-stop-bit lets IDLE catch a back-to-back start edge.
                STOP: if (tick) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : BREAK;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= sh;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count       <= count + NW'(accept) - NW'(pop);
            frame_err_o <= fe_set | (frame_err_o & ~clr_err_i);
            overrun_o   <= ovr_set | (overrun_o & ~clr_err_i);
        end
    end
endmodule
